// File: rtl/core_host_ctrl.sv
// Host-side controller: streams weights/activations into SRAM, kicks the
// corelet, waits for completion and drains result words to the host.
module core_host_ctrl #(
  parameter int W_WORDS   = 72,
  parameter int ACT_WORDS = 36,
  parameter int OP_WORDS  = 16,
  parameter int TIMEOUT   = 4096
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         go,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [31:0]  in_data,
  output logic [31:0]  W_d,
  output logic [6:0]   W_addr,
  output logic         W_cen,
  output logic         W_wen,
  output logic [31:0]  ACT_d,
  output logic [6:0]   ACT_addr,
  output logic         ACT_cen,
  output logic         ACT_wen,
  output logic [8:0]   OP_addr,
  output logic         OP_cen,
  output logic         OP_wen,
  input  logic [127:0] OP_q,
  output logic         mem_sel,
  output logic         seq_begin,
  input  logic         seq_done,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out_data,
  output logic         busy,
  output logic         err
);

  localparam int M1 = (W_WORDS > ACT_WORDS) ? W_WORDS : ACT_WORDS;
  localparam int M2 = (M1 > OP_WORDS) ? M1 : OP_WORDS;
  localparam int M3 = (M2 > TIMEOUT) ? M2 : TIMEOUT;
  localparam int CW = $clog2(M3 + 1);

  localparam logic [CW-1:0] C_W  = CW'(W_WORDS - 1);
  localparam logic [CW-1:0] C_A  = CW'(ACT_WORDS - 1);
  localparam logic [CW-1:0] C_OP = CW'(OP_WORDS);
  localparam logic [CW-1:0] C_TO = CW'(TIMEOUT - 1);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_LDW   = 3'd1;
  localparam logic [2:0] S_LDA   = 3'd2;
  localparam logic [2:0] S_START = 3'd3;
  localparam logic [2:0] S_WAIT  = 3'd4;
  localparam logic [2:0] S_DRAIN = 3'd5;

  logic [2:0]    r_state;
  logic [CW-1:0] r_cnt;
  logic          r_inflight;
  logic          r_out_valid;
  logic [127:0]  r_out_data;
  logic          r_err;

  logic w_ldw;
  logic w_lda;
  logic w_drain;
  logic w_xfer;
  logic w_wxfer;
  logic w_axfer;
  logic w_oxfer;
  logic w_rd;
  logic w_last;

  assign w_ldw   = (r_state == S_LDW);
  assign w_lda   = (r_state == S_LDA);
  assign w_drain = (r_state == S_DRAIN);

  assign in_ready = w_ldw | w_lda;
  assign w_xfer   = in_valid & in_ready;
  assign w_wxfer  = w_xfer & w_ldw;
  assign w_axfer  = w_xfer & w_lda;

  assign W_cen  = ~w_wxfer;
  assign W_wen  = ~w_wxfer;
  assign W_addr = w_wxfer ? 7'(r_cnt) : 7'd0;
  assign W_d    = w_wxfer ? in_data : 32'd0;

  assign ACT_cen  = ~w_axfer;
  assign ACT_wen  = ~w_axfer;
  assign ACT_addr = w_axfer ? 7'(r_cnt) : 7'd0;
  assign ACT_d    = w_axfer ? in_data : 32'd0;

  // A read is never in flight while out_valid is set, so on a transfer
  // with no read pending the word leaving is index r_cnt-1.
  assign w_oxfer = r_out_valid & out_ready;
  assign w_rd    = w_drain & ~r_inflight & (r_cnt < C_OP)
                 & (~r_out_valid | out_ready);
  assign w_last  = w_drain & w_oxfer & ~r_inflight & (r_cnt == C_OP);

  assign OP_cen  = ~w_rd;
  assign OP_wen  = 1'b1;
  assign OP_addr = w_rd ? 9'(r_cnt) : 9'd0;

  assign mem_sel   = ~((r_state == S_START) | (r_state == S_WAIT));
  assign seq_begin = (r_state == S_START);
  assign busy      = (r_state != S_IDLE);
  assign err       = r_err;
  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_err   <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (go) begin
            r_state <= S_LDW;
            r_cnt   <= '0;
            r_err   <= 1'b0;
          end
        end
        S_LDW: begin
          if (w_xfer) begin
            if (r_cnt == C_W) begin
              r_state <= S_LDA;
              r_cnt   <= '0;
            end else begin
              r_cnt <= r_cnt + 1'b1;
            end
          end
        end
        S_LDA: begin
          if (w_xfer) begin
            if (r_cnt == C_A) begin
              r_state <= S_START;
              r_cnt   <= '0;
            end else begin
              r_cnt <= r_cnt + 1'b1;
            end
          end
        end
        S_START: begin
          r_state <= S_WAIT;
          r_cnt   <= '0;
        end
        S_WAIT: begin
          if (seq_done) begin
            r_state <= S_DRAIN;
            r_cnt   <= '0;
          end else if (r_cnt == C_TO) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_err   <= 1'b1;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        S_DRAIN: begin
          if (w_rd) begin
            r_cnt <= r_cnt + 1'b1;
          end
          if (w_last) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_cnt   <= '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_inflight  <= 1'b0;
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
    end else begin
      r_inflight <= w_rd;
      if (r_inflight) begin
        r_out_valid <= 1'b1;
        r_out_data  <= OP_q;
      end else if (w_oxfer) begin
        r_out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: doc/core_host_ctrl.md
CORE_HOST_CTRL -- requirements
Module: core_host_ctrl

Interface
REQ-001 Parameters SHALL be: W_WORDS, default 72, weight words loaded (9 kij x 8 rows); ACT_WORDS, default 36, activation words; OP_WORDS, default 16, result words drained; TIMEOUT, default 4096, maximum cycles to wait for seq_done.
REQ-002 clk  in  1  sole clock; all state on rising edge.
REQ-003 reset  in  1  asynchronous, active-low; 0 clears all state immediately.
REQ-004 go  in  1  single-cycle start pulse; honoured only in IDLE.
REQ-005 in_valid/in_ready/in_data  in/out/in  1/1/32  host load stream; a word transfers on in_valid&in_ready.
REQ-006 W_d/W_addr/W_cen/W_wen  out  32/7/1/1  weight SRAM write port; cen and wen active-low.
REQ-007 ACT_d/ACT_addr/ACT_cen/ACT_wen  out  32/7/1/1  activation SRAM write port; cen and wen active-low.
REQ-008 OP_addr/OP_cen/OP_wen  out  9/1/1  result SRAM read port; OP_q  in  128  read data, valid one cycle after OP_cen=0.
REQ-009 mem_sel  out  1  1 = this block owns the SRAM ports; 0 = corelet owns them.
REQ-010 seq_begin  out  1  start pulse to corelet; seq_done  in  1  corelet completion pulse.
REQ-011 out_valid/out_ready/out_data  out/in/out  1/1/128  result stream; a word transfers on out_valid&out_ready.
REQ-012 busy  out  1  state != IDLE; err  out  1  sticky timeout flag.

Function
REQ-013 States SHALL be IDLE, LOAD_W, LOAD_ACT, START, WAIT_DONE, DRAIN.
REQ-014 IDLE: go -> LOAD_W with word counter = 0, err cleared; otherwise hold.
REQ-015 LOAD_W: in_ready=1; each transfer drives W_cen=0, W_wen=0, W_addr=counter, W_d=in_data in the same cycle; counter increments; the transfer with counter = W_WORDS-1 -> LOAD_ACT with counter = 0.
REQ-016 LOAD_ACT: same rules on the ACT port; the transfer with counter = ACT_WORDS-1 -> START.
REQ-017 No SRAM write SHALL occur in any cycle without a transfer; in_valid=0 stalls the counter.
REQ-018 in_ready SHALL be 0 outside LOAD_W and LOAD_ACT.
REQ-019 mem_sel SHALL be 1 in IDLE, LOAD_W, LOAD_ACT and DRAIN, and 0 in START and WAIT_DONE.
REQ-020 START: seq_begin=1 for exactly one cycle; then -> WAIT_DONE with cycle counter = 0.
REQ-021 WAIT_DONE: seq_done=1 -> DRAIN with counter = 0; otherwise the counter increments; counter = TIMEOUT-1 without seq_done -> err=1 and -> IDLE.
REQ-022 seq_done outside WAIT_DONE SHALL be ignored.
REQ-023 DRAIN: at most one OP read outstanding; issue the read (OP_cen=0, OP_wen=1, OP_addr=read index) only when no read is in flight, the read index is < OP_WORDS, and (out_valid=0 or out_ready=1).
REQ-024 OP_q SHALL be captured into out_data the cycle after a read, setting out_valid=1; out_data and out_valid SHALL hold stable until out_ready=1.
REQ-025 The transfer of word OP_WORDS-1 -> IDLE; out_valid=0 the following cycle.
REQ-026 Idle SRAM outputs SHALL be cen=1, wen=1, addr=0, d=0.
REQ-027 The address fields SHALL be zero-extended counter values; counters SHALL never wrap within a state.
REQ-028 go outside IDLE SHALL be ignored.

Reset
REQ-029 While reset=0: state IDLE, all counters 0, in_ready=0, seq_begin=0, out_valid=0, out_data=0, busy=0, err=0, mem_sel=1, and all cen/wen=1.
REQ-030 Reset asserted mid-operation SHALL abort immediately with no partial SRAM write and no pending out_valid; the first cycle after release SHALL be IDLE.

Verification
REQ-031 go; stream 72 words, then 36 words, with in_valid always 1 -> W addresses 0..71, ACT addresses 0..35 written in order; seq_begin high exactly one cycle after the last ACT write.
REQ-032 in_valid toggling 1/0 during load -> writes only on valid cycles; addresses contiguous; total 108 writes.
REQ-033 seq_done 10 cycles after seq_begin; OP_q = 128'h(index) per read; out_ready=1 -> 16 outputs with values 0..15 in order; busy falls after the 16th transfer.
REQ-034 out_ready held 0 for 5 cycles during DRAIN -> out_data stable; no further OP reads until out_ready=1; no words lost or duplicated.
REQ-035 seq_done never asserted -> err=1 after 4096 WAIT_DONE cycles; state IDLE; a new go clears err.
REQ-036 reset=0 pulsed during LOAD_ACT at word 20 -> all outputs at reset values; no SRAM write that cycle; the following go restarts at W_addr 0.
